comparator_status_scheduler: RTL and testbench
==============================================

// Module: comparator_status_scheduler
// PURPOSE
//  Collects task-completion events (task id, mismatch, logical core) from NUM_REQ fingerprint/comparator channels.
//  Round-robin arbitrates them into a small FIFO and replays them one at a time on the status-write handshake
//  of the comparator CSR register block (comparator_status_write / csr_status_ack).
//  Sits between the comparator channels and the CSR block; no event is lost while the CSR block holds its irq.
// PARAMETERS
//  NUM_REQ        2   number of requesting channels (1..4)
//  FIFO_DEPTH     4   event FIFO entries, power of two
//  KEY_WIDTH      4   task id width (= CRC_KEY_WIDTH)
//  TIMEOUT_CYCLES 255 ack timeout, used only with STATUS_SCHED_TIMEOUT_EN
// PORTS
//  clk                          in   1            system clock
//  reset                        in   1            synchronous, active-high
//  req_valid                    in   NUM_REQ      channel i has an event
//  req_task_id                  in   NUM_REQ*4    task id, channel i at [4i+3:4i]
//  req_mismatch                 in   NUM_REQ      1 = fingerprint mismatch
//  req_logical_core_id          in   NUM_REQ*2    failing logical core, channel i at [2i+1:2i]
//  req_ready                    out  NUM_REQ      one-hot grant; event taken on valid&ready
//  comparator_status_write      out  1            registered request to CSR block
//  comparator_task_id           out  KEY_WIDTH    head-of-FIFO task id
//  comparator_mismatch_detected out  1            head-of-FIFO mismatch
//  comparator_logical_core_id   out  2            head-of-FIFO logical core
//  csr_status_ack               in   1            one-cycle ack from CSR block
//  pending_count                out  log2(D)+1    FIFO occupancy
//  timeout_flag                 out  1            sticky ack-timeout flag (0 without macro)
// BEHAVIOUR
//  Reset (sync): FIFO empty, RR pointer=0, FSM=IDLE; all outputs 0. Reset mid-handshake drops write next edge, flushes FIFO.
//  Arbiter: combinational RR over req_valid starting at pointer; req_ready one-hot, all 0 when FIFO full.
//   Pointer <= granted+1 (mod NUM_REQ) on each accepted event; unchanged otherwise.
//  FIFO: at most one push per cycle; push and pop in same cycle allowed, including when full (pop frees slot
//   only next cycle: ready stays 0 while full). pending_count updates on the edge after push/pop.
//  FSM (registered outputs):
//   IDLE : FIFO non-empty -> ISSUE, comparator_status_write<=1, data<=FIFO head.
//   ISSUE: hold write and data stable; on csr_status_ack=1 -> GAP, write<=0, pop FIFO.
//   GAP  : write stays 0 exactly one cycle (CSR block must see write low in its idle state) -> IDLE.
//  Min spacing: write-low for >=2 cycles between events; event data never changes while write=1.
//  Ack while not in ISSUE is ignored. Order of events = acceptance order (FIFO), no reordering by mismatch.
// CONFIGURATION
//  STATUS_SCHED_TIMEOUT_EN defined: cycle counter runs in ISSUE; reaching TIMEOUT_CYCLES without ack -> drop
//   head entry (pop), write<=0, go GAP, set timeout_flag (sticky until reset). Counter clears on entering ISSUE.
//  Undefined: ISSUE waits for ack indefinitely; timeout_flag tied 0; no counter logic.
// STRUCTURE
//  defines.v: CRC_KEY_WIDTH, FSM state encodings (SCHED_IDLE/SCHED_ISSUE/SCHED_GAP), default timeout.
//  Sub-module status_event_fifo (width KEY_WIDTH+3, depth FIFO_DEPTH, push/pop/full/empty/count).
//  Arbiter + FSM + timeout counter live in this module.
// TESTING
//  1 single event ch0 {task 5, mismatch 1, core 2}; ack 3 cycles after write -> write high 4 cycles, outputs 5/1/2, write low 1 cycle after ack.
//  2 ch0 and ch1 valid continuously, same cycle -> grants alternate ch0,ch1,ch0...; CSR sees events in that order.
//  3 5 events pushed, no ack, D=4 -> 4 accepted, pending_count=4, req_ready=0; one ack -> pop, ready reasserts next cycle.
//  4 ack held high outside ISSUE / during GAP -> no pop, no extra write; pending_count unchanged.
//  5 reset asserted while write=1 with 3 pending -> next cycle write=0, pending_count=0, ready after reset released.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> write drops after 8 cycles, timeout_flag=1, next entry issued.

Source files
------------

// File: rtl/comparator_status_scheduler_pkg.sv
// rtl/comparator_status_scheduler_pkg.sv - shared constants and FSM state type for the status scheduler
// Purpose : default widths, default ack timeout and scheduler state encodings.
// Ports   : none (package).
// Config  : STATUS_SCHED_TIMEOUT_EN selects the ack-timeout logic in the top module.
package comparator_status_scheduler_pkg;

   localparam int CRC_KEY_WIDTH         = 4;
   localparam int SCHED_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      SCHED_IDLE  = 2'd0,
      SCHED_ISSUE = 2'd1,
      SCHED_GAP   = 2'd2
   } sched_state_t;

endpackage

// File: rtl/comparator_status_scheduler_fifo.sv
// rtl/comparator_status_scheduler_fifo.sv - event FIFO holding accepted comparator status events
// Purpose : synchronous FIFO, one push and one pop per cycle, head visible combinationally.
// Ports   : i_clk, i_reset (sync, active-high), i_push/i_push_data, i_pop,
//           o_head, o_full, o_empty, o_count (occupancy, $clog2(DEPTH)+1 bits).
module status_event_fifo
   import comparator_status_scheduler_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by overflow.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/comparator_status_scheduler.sv
// rtl/comparator_status_scheduler.sv - round-robin collector replaying comparator events to the CSR block
// Purpose : round-robin arbitrates NUM_REQ channel events into a FIFO and replays each one on the
//           comparator_status_write / csr_status_ack handshake, with a forced low gap between events.
// Ports   : i_clk, i_reset (sync, active-high); i_req_valid/i_req_task_id/i_req_mismatch/
//           i_req_logical_core_id per channel, o_req_ready one-hot grant; o_comparator_status_write,
//           o_comparator_task_id, o_comparator_mismatch_detected, o_comparator_logical_core_id,
//           i_csr_status_ack; o_pending_count FIFO occupancy; o_timeout_flag sticky ack timeout.
// Config  : STATUS_SCHED_TIMEOUT_EN enables the ack timeout (TIMEOUT_CYCLES); otherwise flag is 0.
module comparator_status_scheduler
   import comparator_status_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int KEY_WIDTH  = CRC_KEY_WIDTH
`ifdef STATUS_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_DEFAULT
`endif
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   input  logic [NUM_REQ*KEY_WIDTH-1:0]    i_req_task_id,
   input  logic [NUM_REQ-1:0]              i_req_mismatch,
   input  logic [NUM_REQ*2-1:0]            i_req_logical_core_id,
   output logic [NUM_REQ-1:0]              o_req_ready,
   output logic                            o_comparator_status_write,
   output logic [KEY_WIDTH-1:0]            o_comparator_task_id,
   output logic                            o_comparator_mismatch_detected,
   output logic [1:0]                      o_comparator_logical_core_id,
   input  logic                            i_csr_status_ack,
   output logic [$clog2(FIFO_DEPTH):0]     o_pending_count,
   output logic                            o_timeout_flag
);

   localparam int EW = KEY_WIDTH + 3;
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t            r_state;
   logic [IW-1:0]           r_rr_ptr;
   logic                    r_write;
   logic [KEY_WIDTH-1:0]    r_task_id;
   logic                    r_mismatch;
   logic [1:0]              r_core_id;

   logic [NUM_REQ-1:0]      w_grant;
   logic [IW-1:0]           w_grant_idx;
   logic [IW-1:0]           w_next_ptr;
   logic                    w_found;
   int                      w_idx;
   logic [EW-1:0]           w_push_data;
   logic                    w_pop;
   logic [EW-1:0]           w_head;
   logic                    w_full;
   logic                    w_empty;
   logic [$clog2(FIFO_DEPTH):0] w_count;

   // Round-robin search starting at the pointer; a full FIFO blocks every grant, and
   // since full is registered a same-cycle pop does not reopen ready until next cycle.
   always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_found     = 1'b0;
      w_idx       = 0;
      w_push_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_found && !w_full && i_req_valid[w_idx]) begin
            w_found        = 1'b1;
            w_grant[w_idx] = 1'b1;
            w_grant_idx    = IW'(w_idx);
            w_push_data    = {i_req_task_id[w_idx*KEY_WIDTH +: KEY_WIDTH],
                              i_req_mismatch[w_idx],
                              i_req_logical_core_id[w_idx*2 +: 2]};
         end
      end
   end

   assign w_next_ptr = (w_grant_idx == IW'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;

`ifdef STATUS_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_timeout_flag;
   logic          w_timeout;

   // Counter starts at 0 on the first ISSUE cycle, so write stays high TIMEOUT_CYCLES cycles.
   assign w_timeout = (r_state == SCHED_ISSUE) && !i_csr_status_ack &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_pop          = (r_state == SCHED_ISSUE) && (i_csr_status_ack || w_timeout);
   assign o_timeout_flag = r_timeout_flag;
`else
   assign w_pop          = (r_state == SCHED_ISSUE) && i_csr_status_ack;
   assign o_timeout_flag = 1'b0;
`endif

   status_event_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_found),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= SCHED_IDLE;
         r_rr_ptr   <= '0;
         r_write    <= 1'b0;
         r_task_id  <= '0;
         r_mismatch <= 1'b0;
         r_core_id  <= '0;
`ifdef STATUS_SCHED_TIMEOUT_EN
         r_to_cnt       <= '0;
         r_timeout_flag <= 1'b0;
`endif
      end else begin
         if (w_found) r_rr_ptr <= w_next_ptr;
         case (r_state)
            SCHED_IDLE: begin
               if (!w_empty) begin
                  r_state <= SCHED_ISSUE;
                  r_write <= 1'b1;
                  {r_task_id, r_mismatch, r_core_id} <= w_head;
`ifdef STATUS_SCHED_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end
            SCHED_ISSUE: begin
               if (w_pop) begin
                  r_state <= SCHED_GAP;
                  r_write <= 1'b0;
`ifdef STATUS_SCHED_TIMEOUT_EN
                  if (w_timeout) r_timeout_flag <= 1'b1;
`endif
               end
`ifdef STATUS_SCHED_TIMEOUT_EN
               else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            // One forced low cycle; IDLE adds the second before the next write.
            SCHED_GAP: r_state <= SCHED_IDLE;
            default:   r_state <= SCHED_IDLE;
         endcase
      end
   end

   assign o_req_ready                    = w_grant;
   assign o_comparator_status_write      = r_write;
   assign o_comparator_task_id           = r_task_id;
   assign o_comparator_mismatch_detected = r_mismatch;
   assign o_comparator_logical_core_id   = r_core_id;
   assign o_pending_count                = w_count;

endmodule

// File: tb/tb_comparator_status_scheduler.sv
// tb/tb_comparator_status_scheduler.sv - directed table-driven bench for comparator_status_scheduler
module tb_comparator_status_scheduler;

   localparam int NREQ = 2;
   localparam int KW   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*KW-1:0] req_task_id;
   logic [NREQ-1:0]   req_mismatch;
   logic [NREQ*2-1:0] req_core;
   logic [NREQ-1:0]   req_ready;
   logic              write;
   logic [KW-1:0]     task_id;
   logic              mismatch;
   logic [1:0]        core_id;
   logic              ack;
   logic [2:0]        pending;
   logic              timeout_flag;

   always #5 clk = ~clk;

   comparator_status_scheduler #(
      .NUM_REQ    (NREQ),
      .FIFO_DEPTH (4),
      .KEY_WIDTH  (KW)
`ifdef STATUS_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .i_clk                          (clk),
      .i_reset                        (reset),
      .i_req_valid                    (req_valid),
      .i_req_task_id                  (req_task_id),
      .i_req_mismatch                 (req_mismatch),
      .i_req_logical_core_id          (req_core),
      .o_req_ready                    (req_ready),
      .o_comparator_status_write      (write),
      .o_comparator_task_id           (task_id),
      .o_comparator_mismatch_detected (mismatch),
      .o_comparator_logical_core_id   (core_id),
      .i_csr_status_ack               (ack),
      .o_pending_count                (pending),
      .o_timeout_flag                 (timeout_flag)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         ch;
      logic [3:0] tid;
      logic       mis;
      logic [1:0] core;
      int         ack_delay;
      logic [3:0] exp_tid;
      logic       exp_mis;
      logic [1:0] exp_core;
      int         exp_high;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ch(input int ch, input logic [3:0] t, input logic m,
                           input logic [1:0] c, input logic v);
      req_task_id[ch*KW +: KW] = t;
      req_mismatch[ch]         = m;
      req_core[ch*2 +: 2]      = c;
      req_valid[ch]            = v;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      ack       = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_write(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (write === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk({name, "_write_wait"}, 0, 1);
   endtask

   task automatic service(input string name, input logic [3:0] exp_tid);
      bit ok;
      wait_write(name, ok);
      if (ok) begin
         chk({name, "_task"}, task_id, exp_tid);
         ack = 1'b1;
         tick();
         ack = 1'b0;
         chk({name, "_drop"}, write, 0);
      end
   endtask

   initial begin
      bit ok;
      int high;
      int exp_g[5];

      vecs[0] = '{ch: 0, tid: 4'd5,  mis: 1'b1, core: 2'd2, ack_delay: 3,
                  exp_tid: 4'd5,  exp_mis: 1'b1, exp_core: 2'd2, exp_high: 4};
      vecs[1] = '{ch: 1, tid: 4'd9,  mis: 1'b0, core: 2'd1, ack_delay: 0,
                  exp_tid: 4'd9,  exp_mis: 1'b0, exp_core: 2'd1, exp_high: 1};
      vecs[2] = '{ch: 1, tid: 4'd15, mis: 1'b1, core: 2'd3, ack_delay: 1,
                  exp_tid: 4'd15, exp_mis: 1'b1, exp_core: 2'd3, exp_high: 2};
      vecs[3] = '{ch: 0, tid: 4'd0,  mis: 1'b0, core: 2'd0, ack_delay: 2,
                  exp_tid: 4'd0,  exp_mis: 1'b0, exp_core: 2'd0, exp_high: 3};

      req_task_id  = '0;
      req_mismatch = '0;
      req_core     = '0;
      do_reset();

      chk("rst_write", write, 0);
      chk("rst_pending", pending, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_task", task_id, 0);
      chk("rst_timeout", timeout_flag, 0);

      // Single events with varying ack latency.
      for (int i = 0; i < 4; i++) begin
         drive_ch(vecs[i].ch, vecs[i].tid, vecs[i].mis, vecs[i].core, 1'b1);
         #1;
         chk($sformatf("v%0d_ready", i), req_ready, 1 << vecs[i].ch);
         tick();
         drive_ch(vecs[i].ch, 4'd0, 1'b0, 2'd0, 1'b0);
         chk($sformatf("v%0d_pending", i), pending, 1);
         wait_write($sformatf("v%0d", i), ok);
         if (ok) begin
            chk($sformatf("v%0d_task", i), task_id, vecs[i].exp_tid);
            chk($sformatf("v%0d_mis", i), mismatch, vecs[i].exp_mis);
            chk($sformatf("v%0d_core", i), core_id, vecs[i].exp_core);
            high = 1;
            repeat (vecs[i].ack_delay) begin
               tick();
               if (write === 1'b1) high++;
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            chk($sformatf("v%0d_high", i), high, vecs[i].exp_high);
            chk($sformatf("v%0d_drop", i), write, 0);
            chk($sformatf("v%0d_popped", i), pending, 0);
            tick();
            chk($sformatf("v%0d_gap", i), write, 0);
         end
      end

      // Two channels continuously valid: grants alternate until the FIFO fills.
      do_reset();
      exp_g = '{1, 2, 1, 2, 0};
      drive_ch(0, 4'd1, 1'b0, 2'd1, 1'b1);
      drive_ch(1, 4'd2, 1'b1, 2'd3, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("rr_grant%0d", i), req_ready, exp_g[i]);
         tick();
      end
      req_valid = '0;
      chk("rr_pending", pending, 4);
      service("rr_e0", 4'd1);
      service("rr_e1", 4'd2);
      service("rr_e2", 4'd1);
      service("rr_e3", 4'd2);

      // Five events, no ack: four accepted, ready returns one cycle after the pop.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_ch(0, 4'(i + 1), 1'b0, 2'd0, 1'b1);
         @(negedge clk);
         chk($sformatf("full_ready%0d", i), req_ready, (i < 4) ? 1 : 0);
         tick();
      end
      chk("full_pending", pending, 4);
      chk("full_write", write, 1);
      chk("full_head", task_id, 1);
      ack = 1'b1;
      @(negedge clk);
      chk("full_ready_popcycle", req_ready, 0);
      tick();
      ack = 1'b0;
      chk("full_after_pop", pending, 3);
      @(negedge clk);
      chk("full_ready_again", req_ready, 1);
      tick();
      req_valid = '0;
      chk("full_refill", pending, 4);
      service("full_e1", 4'd2);
      service("full_e2", 4'd3);
      service("full_e3", 4'd4);
      service("full_e4", 4'd5);
      chk("full_drained", pending, 0);

      // Ack outside ISSUE is ignored.
      do_reset();
      ack = 1'b1;
      repeat (3) tick();
      chk("idle_ack_pending", pending, 0);
      chk("idle_ack_write", write, 0);
      ack = 1'b0;
      drive_ch(0, 4'd7, 1'b0, 2'd0, 1'b1);
      tick();
      drive_ch(0, 4'd8, 1'b0, 2'd0, 1'b1);
      tick();
      req_valid = '0;
      chk("gap_pending2", pending, 2);
      wait_write("gap_first", ok);
      chk("gap_first_task", task_id, 7);
      ack = 1'b1;
      tick();
      chk("gap_write_low", write, 0);
      chk("gap_pending1", pending, 1);
      tick();
      chk("gap_ack_write", write, 0);
      chk("gap_ack_pending", pending, 1);
      ack = 1'b0;
      tick();
      chk("gap_next_write", write, 1);
      chk("gap_next_task", task_id, 8);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("gap_last_pop", pending, 0);
      tick();
      tick();
      chk("gap_no_extra", write, 0);

      // Reset in the middle of a handshake with three events queued.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_ch(0, 4'(i + 3), 1'b1, 2'd1, 1'b1);
         tick();
      end
      req_valid = '0;
      wait_write("mrst", ok);
      chk("mrst_pending3", pending, 3);
      reset = 1'b1;
      tick();
      chk("mrst_write", write, 0);
      chk("mrst_pending", pending, 0);
      reset = 1'b0;
      drive_ch(1, 4'd12, 1'b0, 2'd2, 1'b1);
      @(negedge clk);
      chk("mrst_ready", req_ready, 2);
      tick();
      req_valid = '0;
      chk("mrst_accept", pending, 1);
      service("mrst_e", 4'd12);

`ifdef STATUS_SCHED_TIMEOUT_EN
      // No ack: head dropped after eight write-high cycles, next entry issued.
      do_reset();
      drive_ch(0, 4'd10, 1'b0, 2'd0, 1'b1);
      tick();
      drive_ch(0, 4'd11, 1'b0, 2'd0, 1'b1);
      tick();
      req_valid = '0;
      wait_write("to", ok);
      high = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (write === 1'b1) high++;
         else break;
      end
      chk("to_high", high, 8);
      chk("to_flag", timeout_flag, 1);
      chk("to_pending", pending, 1);
      service("to_next", 4'd11);
      chk("to_flag_sticky", timeout_flag, 1);
`else
      repeat (300) tick();
      chk("to_flag_tied", timeout_flag, 0);
      chk("to_no_write", write, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

endmodule
